// File: rtl/row8_loader_if.sv
// Bundles the serial sample input and the parallel group / sum-tracking outputs of row8_loader.
// Latency: none; this interface is wiring only.
// Backpressure: none; the source paces the stream with din_valid and the loader never stalls it.
interface row8_loader_if #(
   parameter int DW = 12
);
   // Serial sample input and group discard.
   logic          flush;
   logic          din_valid;
   logic [DW-1:0] din;

   // Parallel group presented to the adder.
   logic [DW-1:0] n0;
   logic [DW-1:0] n1;
   logic [DW-1:0] n2;
   logic [DW-1:0] n3;
   logic [DW-1:0] n4;
   logic [DW-1:0] n5;
   logic [DW-1:0] n6;
   logic [DW-1:0] n7;
   logic          out_valid;
   logic [2:0]    row_idx;
   logic          block_done;

   // Tracks which group's sum is currently valid at the adder output.
   logic          sum_valid;
   logic [2:0]    sum_row;

   // Sample source / result observer side.
   modport master (
      output flush, din_valid, din,
      input  n0, n1, n2, n3, n4, n5, n6, n7,
      input  out_valid, row_idx, block_done, sum_valid, sum_row
   );

   // Loader side.
   modport slave (
      input  flush, din_valid, din,
      output n0, n1, n2, n3, n4, n5, n6, n7,
      output out_valid, row_idx, block_done, sum_valid, sum_row
   );
endinterface

// File: rtl/row8_loader.sv
// Gathers serial samples into groups of eight for the 8-input adder and tracks the row index in the block.
// Latency: group is on n0..n7 one edge after its 8th sample; sum_valid follows LAT edges after that.
// Backpressure: none; samples arrive at up to one per clock, and din_valid low simply stalls collection.
module row8_loader #(
   parameter int DW  = 12,
   parameter int LAT = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   row8_loader_if.slave  bus
);

   // Collection state: position within the current group and row within the 8x8 block.
   logic [2:0]    idx;
   logic [2:0]    row_cnt;
   logic [DW-1:0] sh [7];

   // Registered group outputs.
   logic [DW-1:0] n_q [8];
   logic          out_valid_q;
   logic          block_done_q;
   logic [2:0]    row_idx_q;

   // Delay line that follows each issued group through the adder pipeline.
   logic [LAT-1:0] pipe_vld;
   logic [2:0]     pipe_row [LAT];

   // A sample is taken only when flush is low; flush always discards the sample on its edge.
   logic take;
   logic last;

   assign take = bus.din_valid & ~bus.flush;
   assign last = take & (idx == 3'd7);

   // Sample index, row counter and the seven shadow samples of the group in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= 3'd0;
         row_cnt <= 3'd0;
         for (int i = 0; i < 7; i++) begin
            sh[i] <= '0;
         end
      end else if (bus.flush) begin
         idx     <= 3'd0;
         row_cnt <= 3'd0;
      end else if (bus.din_valid) begin
         if (idx == 3'd7) begin
            idx     <= 3'd0;
            row_cnt <= row_cnt + 3'd1;
         end else begin
            for (int i = 0; i < 7; i++) begin
               if (idx == 3'(i)) begin
                  sh[i] <= bus.din;
               end
            end
            idx <= idx + 3'd1;
         end
      end
   end

   // Publish a completed group; n0..n7 and row_idx hold until the next completed group.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            n_q[i] <= '0;
         end
         row_idx_q    <= 3'd0;
         out_valid_q  <= 1'b0;
         block_done_q <= 1'b0;
      end else if (last) begin
         for (int i = 0; i < 7; i++) begin
            n_q[i] <= sh[i];
         end
         n_q[7]       <= bus.din;
         row_idx_q    <= row_cnt;
         out_valid_q  <= 1'b1;
         block_done_q <= (row_cnt == 3'd7);
      end else begin
         out_valid_q  <= 1'b0;
         block_done_q <= 1'b0;
      end
   end

   // Shift {out_valid, row_idx} down the LAT-deep tracker so sum_valid lines up with the adder result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         for (int i = 0; i < LAT; i++) begin
            pipe_row[i] <= 3'd0;
         end
      end else begin
         pipe_vld[0] <= out_valid_q;
         pipe_row[0] <= row_idx_q;
         for (int i = 1; i < LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_row[i] <= pipe_row[i-1];
         end
      end
   end

   assign bus.n0         = n_q[0];
   assign bus.n1         = n_q[1];
   assign bus.n2         = n_q[2];
   assign bus.n3         = n_q[3];
   assign bus.n4         = n_q[4];
   assign bus.n5         = n_q[5];
   assign bus.n6         = n_q[6];
   assign bus.n7         = n_q[7];
   assign bus.out_valid  = out_valid_q;
   assign bus.row_idx    = row_idx_q;
   assign bus.block_done = block_done_q;
   assign bus.sum_valid  = pipe_vld[LAT-1];
   assign bus.sum_row    = pipe_row[LAT-1];

endmodule

// File: tb/tb_row8_loader.sv
// Bench for row8_loader: a table of groups with constant row/sum expectations, plus sequences for flush and reset.
// Latency: checks that each group appears one edge after its 8th sample and that sum_valid follows LAT edges later.
// Backpressure: the bench inserts random din_valid gaps, because the DUT applies no backpressure.
module tb_row8_loader;
   localparam int DW  = 12;
   localparam int LAT = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   row8_loader_if #(.DW(DW)) bus();

   row8_loader #(.DW(DW), .LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [7:0][DW-1:0] n;
      logic [2:0]         row;
      logic               bd;
      int                 sum;
      int                 cyc;
   } grp_t;

   typedef struct {
      logic [DW-1:0] s [8];
      logic [2:0]    row;
      int            sum;
   } vec_t;

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc     = 0;

   grp_t grp_q [$];
   grp_t sum_q [$];

   // Reference model state.
   int            m_idx = 0;
   logic [2:0]    m_row = 3'd0;
   logic [DW-1:0] m_sh [7];

   logic [7:0][DW-1:0] dn;
   logic [7:0][DW-1:0] last_n;

   assign dn = {bus.n7, bus.n6, bus.n5, bus.n4, bus.n3, bus.n2, bus.n1, bus.n0};

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // The downstream adder: sign-extended sum of the eight samples.
   function automatic int sum8(input logic [7:0][DW-1:0] a);
      int s = 0;
      for (int i = 0; i < 8; i++) begin
         s += int'($signed(a[i]));
      end
      return s;
   endfunction

   // Drive one edge's worth of inputs and advance the reference model.
   task automatic drive(input logic v, input logic f, input logic [DW-1:0] d,
                        input bit tab, input logic [2:0] trow, input int tsum);
      grp_t g;
      @(posedge clk);
      #2;
      bus.din_valid = v;
      bus.flush     = f;
      bus.din       = d;
      if (f) begin
         m_idx = 0;
         m_row = 3'd0;
      end else if (v) begin
         if (m_idx < 7) begin
            m_sh[m_idx] = d;
            m_idx++;
         end else begin
            for (int i = 0; i < 7; i++) g.n[i] = m_sh[i];
            g.n[7] = d;
            g.row  = tab ? trow : m_row;
            g.bd   = (g.row == 3'd7);
            g.sum  = tab ? tsum : sum8(g.n);
            g.cyc  = cyc + 1;
            grp_q.push_back(g);
            sum_q.push_back(g);
            m_idx = 0;
            m_row = m_row + 3'd1;
         end
      end
   endtask

   task automatic samp(input logic [DW-1:0] d);
      drive(1'b1, 1'b0, d, 1'b0, 3'd0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, 3'd0, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_block_done"}, bus.block_done, 0);
      chk({tag, "_sum_valid"}, bus.sum_valid, 0);
      chk({tag, "_row_idx"}, bus.row_idx, 0);
      chk({tag, "_sum_row"}, bus.sum_row, 0);
      for (int i = 0; i < 8; i++) chk($sformatf("%s_n%0d", tag, i), dn[i], 0);
   endtask

   // Scoreboard: pop and compare whenever the DUT issues a group or a sum strobe.
   always @(negedge clk) begin
      grp_t g;
      if (rst_n) begin
         if (bus.out_valid === 1'b1) begin
            if (grp_q.size() == 0) begin
               vec_cnt++;
               err_cnt++;
               $display("FAIL spurious_out_valid: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
               g = grp_q.pop_front();
               for (int i = 0; i < 8; i++) chk($sformatf("n%0d", i), dn[i], g.n[i]);
               chk("row_idx", bus.row_idx, g.row);
               chk("block_done", bus.block_done, g.bd);
               chk("out_valid_cycle", cyc, g.cyc);
               last_n = g.n;
            end
         end else if (bus.block_done !== 1'b0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL lone_block_done: got %b, expected 0 (cycle %0d)", bus.block_done, cyc);
         end
         if (bus.sum_valid === 1'b1) begin
            if (sum_q.size() == 0) begin
               vec_cnt++;
               err_cnt++;
               $display("FAIL spurious_sum_valid: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
               g = sum_q.pop_front();
               chk("sum_row", bus.sum_row, g.row);
               chk("adder_sum", sum8(dn), g.sum);
               chk("sum_valid_cycle", cyc, g.cyc + LAT);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tab [4];

      tab[0].s   = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
      tab[0].row = 3'd0;
      tab[0].sum = 36;
      tab[1].s   = '{12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800};
      tab[1].row = 3'd1;
      tab[1].sum = -16384;
      tab[2].s   = '{12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF};
      tab[2].row = 3'd2;
      tab[2].sum = 16376;
      tab[3].s   = '{12'hFFF, 12'd1, 12'hFFE, 12'd2, 12'h800, 12'h7FF, 12'd0, 12'd5};
      tab[3].row = 3'd3;
      tab[3].sum = 4;

      for (int i = 0; i < 7; i++) m_sh[i] = '0;
      bus.din_valid = 1'b0;
      bus.flush     = 1'b0;
      bus.din       = '0;
      last_n        = '0;

      #1 rst_n = 1'b0;
      #2;
      chk_zero("reset");
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Table groups; the first is back-to-back, the rest have random din_valid gaps.
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, tab[t].s[k], 1'b1, tab[t].row, tab[t].sum);
            if (t > 0 && k < 7) idle($urandom_range(0, 2));
         end
         idle(1);
      end
      idle(10);

      // 72 continuous samples from row 0: rows 0..7, block_done on row 7, then row 0 again.
      drive(1'b0, 1'b1, '0, 1'b0, 3'd0, 0);
      for (int i = 0; i < 72; i++) samp(DW'($urandom_range(0, 4095)));
      idle(10);

      // Flush cases: 5 samples then flush with din=99, then 7 samples with flush on the completing edge.
      for (int i = 0; i < 5; i++) samp(DW'(50 + i));
      drive(1'b1, 1'b1, 12'd99, 1'b0, 3'd0, 0);
      for (int i = 0; i < 7; i++) samp(DW'(60 + i));
      drive(1'b1, 1'b1, 12'd77, 1'b0, 3'd0, 0);
      idle(1);
      @(negedge clk);
      for (int i = 0; i < 8; i++) chk($sformatf("hold_n%0d", i), dn[i], last_n[i]);
      for (int i = 0; i < 8; i++) samp(DW'(10 + i));
      idle(10);

      // Two groups, a partial third, then asynchronous reset while a sum is still pending.
      for (int i = 0; i < 16; i++) samp(DW'(200 + i));
      samp(12'd216);
      samp(12'd217);
      drive(1'b0, 1'b0, '0, 1'b0, 3'd0, 0);
      #1 rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      sum_q.delete();
      m_idx = 0;
      m_row = 3'd0;
      for (int i = 0; i < 7; i++) m_sh[i] = '0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) samp(DW'(300 + i));
      idle(12);

      chk("groups_outstanding", grp_q.size(), 0);
      chk("sums_outstanding", sum_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/row8_loader.md
# row8_loader

Input-side feeder for the eight-input 12-bit signed adder in the DCTQ datapath. Collects a serial stream of two's-complement samples into groups of eight and presents each group in parallel on `n0`..`n7` with a one-cycle `out_valid` strobe. Tracks the row index within an 8x8 block and emits a `sum_valid` strobe aligned to the cycle in which the downstream adder's combinational `sum` output is valid for that group.

## Interface
- `DW`, default 12: sample width, two's complement.
- `LAT`, default 5: adder pipeline depth, as a number of clock edges from group presentation to valid sum.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous discard of the partial group.
- `din_valid`  in  1: `din` is accepted on this edge.
- `din`  in  DW: serial sample.
- `n0`..`n7`  out  DW each: parallel group; `n0` is the first sample received.
- `out_valid`  out  1: one-cycle strobe; new group is present on `n*`.
- `row_idx`  out  3: row number of the group on `n*`, 0..7.
- `block_done`  out  1: strobe coincident with `out_valid` when `row_idx` = 7.
- `sum_valid`  out  1: the adder's `sum` belongs to a group issued LAT edges earlier.
- `sum_row`  out  3: `row_idx` of that group.

## Operation
- Internal 3-bit sample index `idx` and shadow registers `sh0`..`sh6`.
- On an edge with `din_valid`=1 and `flush`=0:
  - If `idx` < 7: `sh[idx]` <= `din`; `idx` increments.
  - If `idx` = 7: `n0..n6` <= `sh0..sh6`, `n7` <= `din`, `idx` <= 0, `out_valid` <= 1.
  - Also when `idx` = 7: `row_idx` <= `row_cnt`, `block_done` <= (`row_cnt` = 7), then `row_cnt` increments and wraps 7 -> 0.
- All other edges: `out_valid` and `block_done` <= 0.
- Holding rules:
  - `n*` and `row_idx` hold until the next completed group.
  - `din_valid`=0 stalls the counter; gaps between samples are allowed anywhere.
- `flush`=1:
  - `idx` <= 0 and `row_cnt` <= 0.
  - The `din` sample on that edge is dropped (flush wins over a simultaneous `din_valid`).
  - `n*`, `row_idx` and the sum-tracking pipeline are not affected.
  - A group completing on a flush edge is not issued.
- Sum tracking:
  - LAT-deep shift register of {valid, row}, loaded from {`out_valid`, `row_idx`}.
  - Its output drives `sum_valid` / `sum_row`.
  - Every issued group produces exactly one `sum_valid` pulse. Back-to-back groups (minimum 8 cycles apart) never collide.
- Width and arithmetic:
  - Samples are passed bit-exact; no sign extension, saturation or reordering.
  - The downstream 15-bit sum cannot overflow for any DW=12 inputs: range -16384..+16376.
- Asynchronous reset (`rst_n` low), including mid-group and mid-pipeline:
  - `idx`, `row_cnt` and `sh*` = 0.
  - Outputs `n0`..`n7`, `row_idx`, `sum_row` = 0; `out_valid`, `block_done`, `sum_valid` = 0.
  - The partial group and all pending `sum_valid` pulses are discarded.
  - The first sample after reset goes to `n0`.

## Timing
- Sample accepted on the rising edge where `din_valid`=1.
- 8th sample accepted at edge E:
  - `n*`, `row_idx` and `out_valid`=1 are visible from just after E until edge E+1.
  - `sum_valid`=1 is registered at edge E+LAT and stays high for one cycle.
  - During that cycle the adder's combinational `sum` is the total of that group.
- Maximum throughput: one sample per clock, i.e. one group per 8 clocks.
- No combinational path from any input to any output.
- Reset deassertion is synchronised externally. The block samples inputs from the first edge with `rst_n` high.

## Test plan
- Reset, then `din` = 1,2,...,8 on consecutive cycles:
  - `n0`=1 ... `n7`=8, `out_valid` high for exactly one cycle after the 8th edge, `row_idx`=0.
  - `sum_valid` high exactly 5 edges later with `sum_row`=0; adder `sum`=36.
- Eight samples of 12'h800 (-2048) with random `din_valid` gaps:
  - Group issued only after the 8th valid edge.
  - `n*` = 12'h800; sum = -16384 (15'h4000) when `sum_valid` is high.
- 64 continuous samples:
  - `row_idx` runs 0..7, `block_done` high only on row 7.
  - 8 `sum_valid` pulses with `sum_row` 0..7.
  - 65th–72nd samples give `row_idx`=0 again.
- 5 samples, then `flush` asserted together with `din_valid` (`din`=99), then 8 samples 10..17:
  - No group issued from the first 5 samples; 99 dropped.
  - Next group `n0`=10 ... `n7`=17 with `row_idx`=0.
  - Earlier `n*` values held until then.
- Two groups issued, then `rst_n` pulled low 2 cycles after the second `out_valid`:
  - All outputs 0 immediately; the pending `sum_valid` never appears.
  - After release, a new group's first sample lands in `n0`.
